// File: rtl/dnn_acc_pkg.sv
// dnn_acc_pkg: constants and helpers shared across the accelerator datapath blocks
package dnn_acc_pkg;
    localparam int DATA_RD_LATENCY = 1;
    localparam int KERNEL_MAX = 3;
    localparam int KSIZE_LSB = 0;
    localparam int KSIZE_MSB = 1;
    function automatic logic [1:0] kernel_k(input logic [1:0] f);
        return (f == 2'd0) ? 2'd1 : f;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push & ~rst)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/data_window.sv
// data_window: buffers BRAM return pixels and assembles sliding kernel-row windows for the PE array
module data_window
    import dnn_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL_SIZE_WIDTH = 2,
    parameter int REG_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rden,
    input  logic                    i_rlast,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    o_stall,
    output logic [3*DATA_WIDTH-1:0] o_window,
    output logic                    o_valid,
    output logic                    o_last,
    input  logic                    i_ready,
    output logic                    o_err_ovf,
    input  logic [REG_WIDTH-1:0]    i_conf_kernelshape
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] STALL_AT = (CW + 1)'(FIFO_DEPTH - DATA_RD_LATENCY);
    logic rd_pend, last_pend, full, empty, pop, unused_conf;
    logic [CW-1:0] count;
    logic [DATA_WIDTH:0] head;
    logic [KERNEL_SIZE_WIDTH-1:0] k, fill_cnt, fill_inc;
    logic [KERNEL_MAX-1:0][DATA_WIDTH-1:0] win, win_nxt;

    sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(rd_pend),
        .wdata({last_pend, i_rdata}),
        .pop(pop),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    assign k = kernel_k(i_conf_kernelshape[KSIZE_MSB:KSIZE_LSB]);
    assign unused_conf = ^i_conf_kernelshape[REG_WIDTH-1:KSIZE_MSB+1];
    assign pop = ~empty & (~o_valid | i_ready);
    // the in-flight read is counted so its return always finds a free slot
    assign o_stall = ({1'b0, count} + {{CW{1'b0}}, rd_pend}) >= STALL_AT;
    assign fill_inc = (fill_cnt >= k) ? k : fill_cnt + 1'b1;
    assign o_window = win;

    always_comb begin
        win_nxt[0] = (k == 2'd1) ? head[DATA_WIDTH-1:0] : win[1];
        win_nxt[1] = (k == 2'd2) ? head[DATA_WIDTH-1:0] : (k == 2'd3) ? win[2] : '0;
        win_nxt[2] = (k == 2'd3) ? head[DATA_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            last_pend <= 1'b0;
            fill_cnt <= '0;
            win <= '0;
            o_valid <= 1'b0;
            o_last <= 1'b0;
            o_err_ovf <= 1'b0;
        end else begin
            rd_pend <= i_rden;
            last_pend <= i_rlast & i_rden;
            if (rd_pend & full & ~pop)
                o_err_ovf <= 1'b1;
            if (pop) begin
                win <= win_nxt;
                // a segment end restarts the fill whether or not it completed a window
                fill_cnt <= head[DATA_WIDTH] ? '0 : fill_inc;
                o_valid <= fill_inc == k;
                o_last <= head[DATA_WIDTH] & (fill_inc == k);
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_window.sv
// tb_data_window: table vectors, corner sequences and random streams checked against a segment/window model
module tb_data_window;
    logic clk = 1'b0;
    logic rst, i_rden, i_rlast, i_ready;
    logic [7:0] i_rdata;
    logic [31:0] i_conf_kernelshape;
    logic o_stall, o_valid, o_last, o_err_ovf;
    logic [23:0] o_window;

    typedef struct packed {
        logic [1:0]      k;
        logic [3:0]      n;
        logic [7:0][7:0] px;
        logic [7:0]      lastm;
        logic [1:0]      rmode;
        logic [3:0]      exp_n;
    } vec_t;

    vec_t vecs [6];
    int n_chk, n_fail, cyc, stall_cnt, issued, rmode;
    bit bp_hold, gaps, prev_hold;
    logic [7:0] pend_px;
    logic [24:0] prev_w;
    logic [8:0] src [$];
    logic [8:0] sent_q [$];
    logic [24:0] exp_q [$];
    logic [24:0] got_q [$];
    int acc_cyc [$];
    int rden_cyc [$];

    data_window dut (
        .clk(clk),
        .rst(rst),
        .i_rden(i_rden),
        .i_rlast(i_rlast),
        .i_rdata(i_rdata),
        .o_stall(o_stall),
        .o_window(o_window),
        .o_valid(o_valid),
        .o_last(o_last),
        .i_ready(i_ready),
        .o_err_ovf(o_err_ovf),
        .i_conf_kernelshape(i_conf_kernelshape)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // a window left waiting must stay put until it is taken
    always @(negedge clk) begin
        if (prev_hold)
            chk("hold_stable", {6'd0, o_valid, o_last, o_window}, {6'd0, 1'b1, prev_w});
        prev_hold = o_valid & ~i_ready & ~rst;
        prev_w = {o_last, o_window};
        if (!rst && o_valid && i_ready) begin
            got_q.push_back({o_last, o_window});
            acc_cyc.push_back(cyc);
        end
        if (o_stall)
            stall_cnt++;
    end

    task automatic step();
        logic [8:0] it;
        @(posedge clk);
        #1;
        i_rdata = pend_px;
        i_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : ~bp_hold;
        if (src.size() > 0 && !o_stall && (!gaps || $urandom_range(0, 3) != 0)) begin
            it = src.pop_front();
            i_rden = 1'b1;
            i_rlast = it[8];
            pend_px = it[7:0];
            issued++;
            rden_cyc.push_back(cyc);
        end else begin
            i_rden = 1'b0;
            i_rlast = 1'($urandom_range(0, 1));
            pend_px = 8'($urandom);
        end
    endtask

    task automatic start(input logic [1:0] kf, input int rm);
        logic [31:0] conf;
        conf = $urandom;
        conf[1:0] = kf;
        i_conf_kernelshape = conf;
        rmode = rm;
        bp_hold = 1'b0;
        src.delete();
        sent_q.delete();
        got_q.delete();
        acc_cyc.delete();
        rden_cyc.delete();
        stall_cnt = 0;
        issued = 0;
    endtask

    task automatic push_item(input logic [8:0] it);
        src.push_back(it);
        sent_q.push_back(it);
    endtask

    // every run of K consecutive pixels inside one segment is a window, oldest in lane 0
    task automatic build_exp(input logic [1:0] kf);
        int k;
        logic [7:0] seg [$];
        logic [23:0] w;
        k = (kf == 2'd0) ? 1 : int'(kf);
        exp_q.delete();
        foreach (sent_q[i]) begin
            seg.push_back(sent_q[i][7:0]);
            if (seg.size() >= k) begin
                w = '0;
                for (int j = 0; j < k; j++)
                    w[8*j +: 8] = seg[seg.size() - k + j];
                exp_q.push_back({sent_q[i][8], w});
            end
            if (sent_q[i][8])
                seg.delete();
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (c < budget && (src.size() > 0 || got_q.size() < exp_q.size())) begin
            step();
            c++;
        end
        repeat (8) step();
        chk("drain_src_empty", src.size(), 0);
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size())
                chk($sformatf("%s_win%0d", name, i), {7'd0, got_q[i]}, {7'd0, exp_q[i]});
        chk({name, "_ovf"}, o_err_ovf, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] kr;
        int n;
        rst = 1'b1;
        i_rden = 1'b0;
        i_rlast = 1'b0;
        i_rdata = '0;
        i_ready = 1'b0;
        i_conf_kernelshape = '0;
        pend_px = '0;
        // pixel 0 sits in the low byte of px
        vecs[0] = '{k: 2'd3, n: 4'd6, px: {8'd0, 8'd0, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10},
                    lastm: 8'b0010_0000, rmode: 2'd0, exp_n: 4'd4};
        vecs[1] = '{k: 2'd2, n: 4'd5, px: {8'd0, 8'd0, 8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    lastm: 8'b0001_0100, rmode: 2'd0, exp_n: 4'd3};
        vecs[2] = '{k: 2'd0, n: 4'd2, px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd7},
                    lastm: 8'b0000_0010, rmode: 2'd0, exp_n: 4'd2};
        vecs[3] = '{k: 2'd1, n: 4'd2, px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd7},
                    lastm: 8'b0000_0010, rmode: 2'd0, exp_n: 4'd2};
        vecs[4] = '{k: 2'd3, n: 4'd5, px: {8'd0, 8'd0, 8'd0, 8'd32, 8'd31, 8'd30, 8'd21, 8'd20},
                    lastm: 8'b0001_0010, rmode: 2'd0, exp_n: 4'd1};
        vecs[5] = '{k: 2'd3, n: 4'd8, px: {8'd67, 8'd66, 8'd65, 8'd64, 8'd63, 8'd62, 8'd61, 8'd60},
                    lastm: 8'b1000_0000, rmode: 2'd1, exp_n: 4'd6};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", o_valid, 0);
        chk("reset_last", o_last, 0);
        chk("reset_window", o_window, 0);
        chk("reset_stall", o_stall, 0);
        chk("reset_ovf", o_err_ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            start(vecs[v].k, int'(vecs[v].rmode));
            for (int i = 0; i < int'(vecs[v].n); i++)
                push_item({vecs[v].lastm[i], vecs[v].px[i]});
            build_exp(vecs[v].k);
            drain(300);
            compare($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_count_table", v), got_q.size(), vecs[v].exp_n);
            if (v == 0) begin
                chk("v0_latency", (acc_cyc.size() > 0) ? acc_cyc[0] - rden_cyc[2] : -1, 3);
                chk("v0_throughput", (acc_cyc.size() >= 4) ? acc_cyc[3] - acc_cyc[0] : -1, 3);
                chk("v0_no_stall", stall_cnt, 0);
            end
        end

        // back-pressure: one window held, three pixels buffered, then the source must stop
        start(2'd1, 2);
        bp_hold = 1'b1;
        for (int i = 0; i < 8; i++)
            push_item({i == 7, 8'(70 + i)});
        build_exp(2'd1);
        repeat (15) step();
        chk("bp_issued", issued, 4);
        chk("bp_stall", o_stall, 1);
        chk("bp_ovf", o_err_ovf, 0);
        chk("bp_none_taken", got_q.size(), 0);
        bp_hold = 1'b0;
        drain(300);
        compare("bp");

        // reset with a read in flight, then a clean segment
        start(2'd2, 0);
        for (int i = 0; i < 3; i++)
            push_item({1'b0, 8'(40 + i)});
        repeat (3) step();
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_rden = 1'b0;
        i_rdata = pend_px;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_rden = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_window", o_window, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_ovf", o_err_ovf, 0);
        start(2'd2, 0);
        push_item({1'b0, 8'd50});
        push_item({1'b1, 8'd51});
        build_exp(2'd2);
        drain(100);
        compare("post_rst");
        chk("post_rst_window", (got_q.size() > 0) ? {7'd0, got_q[0]} : 32'hffff_ffff, {8'd0, 1'b1, 8'd0, 8'd51, 8'd50});

        gaps = 1'b1;
        for (int r = 0; r < 8; r++) begin
            kr = 2'($urandom_range(0, 3));
            start(kr, 1);
            n = $urandom_range(8, 30);
            for (int i = 0; i < n; i++)
                push_item({(i == n - 1) || ($urandom_range(0, 3) == 0), 8'($urandom)});
            build_exp(kr);
            drain(1000);
            compare($sformatf("rand%0d", r));
        end
        gaps = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_window.md
# data_window

Downstream neighbour of `data_req`: captures the pixel stream returned by the data block RAM one cycle after each read enable, buffers it in a small FIFO, and assembles a sliding window of up to 3 pixels (one kernel row) for the PE array. It back-pressures `data_req` through `o_stall` so no returned pixel is ever lost. Row-segment boundaries travel with the data so windows never straddle two input rows.

## Interface
- `DATA_WIDTH`, 8: pixel width in bits.
- `KERNEL_SIZE_WIDTH`, 2: width of the kernel-size field.
- `REG_WIDTH`, 32: configuration register width.
- `FIFO_DEPTH`, 4: return-buffer entries; power of two, minimum 4.
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset, synchronous, active-high.
- `i_rden`  in  1: BRAM read enable issued this cycle (`data_req` `o_rden`).
- `i_rlast`  in  1: qualified by `i_rden`; marks the last read of a kernel-row segment.
- `i_rdata`  in  DATA_WIDTH: BRAM read data, valid exactly 1 cycle after `i_rden`.
- `o_stall`  out  1: back-pressure to `data_req`.
- `o_window`  out  3*DATA_WIDTH: lane 0 = oldest pixel; lanes ≥ K are zero.
- `o_valid`  out  1: `o_window` holds a valid window.
- `o_last`  out  1: qualified by `o_valid`; window holds the last pixel of its segment.
- `i_ready`  in  1: PE accepts the window when `o_valid & i_ready`.
- `o_err_ovf`  out  1: sticky; FIFO write attempted while full.
- `i_conf_kernelshape`  in  REG_WIDTH: bits [1:0] = K (1..3; 0 treated as 1).

## Operation
- Return capture: `rd_pend <= i_rden`, `last_pend <= i_rlast & i_rden`. When `rd_pend`=1, push {`last_pend`, `i_rdata`} into the FIFO.
- Occupancy = FIFO count + `rd_pend`. `o_stall` = (occupancy ≥ FIFO_DEPTH−1). It depends on registers only, with no combinational path from `i_rden`. This guarantees no overflow with one read in flight.
- Pop condition: FIFO non-empty and (`~o_valid` | `i_ready`).
- On pop: shift the pixel into the window, with the newest at lane K−1 and older pixels moving toward lane 0. `fill_cnt` increments and saturates at K.
- After a pop that leaves `fill_cnt` = K, the registered `o_valid` is 1 in the next cycle, with `o_last` = the popped entry's last flag. Sliding behaviour: once filled, every further pop produces a new window.
- After a pop carrying the last flag, `fill_cnt` is cleared to 0 once that window is issued. The next segment refills from empty. If a segment ends before K pixels have arrived, no window is produced; the partial pixels are discarded and `fill_cnt` resets.
- If `o_valid & i_ready` occurs with no pop, `o_valid` drops next cycle. Otherwise `o_valid` holds and `o_window`/`o_last` remain stable.
- Push and pop in the same cycle: count unchanged; correct even when the FIFO is full.
- Push while full (only possible on protocol violation): data dropped and `o_err_ovf` set until `rst`.
- K is sampled continuously. Software changes K only while idle (FIFO empty, `o_valid`=0).

## Timing
- Reset values: `o_stall`=0, `o_valid`=0, `o_last`=0, `o_window`=0, `o_err_ovf`=0; FIFO empty, `rd_pend`=0, `fill_cnt`=0.
- Reset mid-operation flushes everything, including the in-flight read. Its data returning in the cycle after `rst` is ignored.
- Latency from `i_rden` to `o_valid` for the K-th pixel, with the FIFO empty and `i_ready`=1: 3 cycles. Cycle t+1 push; t+2 pop/shift; t+3 `o_valid`.
- Sustained throughput: 1 window/cycle with `i_ready` held high and `i_rden` continuous; `o_stall` never asserts in that case.
- With `i_ready`=0, `o_stall` rises no later than the cycle occupancy reaches FIFO_DEPTH−1.

## Structure
- Shared package `dnn_acc_pkg`: `DATA_RD_LATENCY`=1, `KERNEL_MAX`=3, kernel-size field position [1:0].
- Sub-module `sync_fifo`: width DATA_WIDTH+1, depth FIFO_DEPTH, with count output. The window/shift logic and stall logic live in `data_window`.

## Test plan
- Stream, K=3, pixels 10..15 with `i_rlast` on 15, `i_ready`=1 → four windows {10,11,12} … {13,14,15}. The first window appears 3 cycles after the third `i_rden`; `o_last`=1 only on {13,14,15}.
- Two segments, K=2: 1,2,3(last) then 4,5(last) → windows {1,2},{2,3}L,{4,5}L; no window {3,4}.
- Back-pressure: `i_ready`=0, `i_rden` gated by `o_stall` → `o_stall` asserts at occupancy 3 and `o_err_ovf` stays 0. After `i_ready` is raised, all pixels are delivered in order with none lost.
- K=0 and K=1, pixels 7,8 → single-pixel windows {7},{8}; lanes 1–2 are zero.
- Short segment, K=3: 20,21(last) → no window; the next segment 30,31,32 yields {30,31,32}.
- `rst` asserted the cycle after an `i_rden` with 2 entries buffered → all outputs 0 next cycle; the returning pixel is not pushed; the post-reset stream starts clean.
